inv_sub_bytes_seq: RTL and testbench

- Byte-serial AES InvSubBytes engine: the decryption-side inverse of the combinational SubBytes stage.
- Accepts a vecSize x regSize state over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through replicated inverse S-box ROMs, then presents the result over a valid/ready output handshake.
- Sits in the SIMD decrypt datapath between InvShiftRows and AddRoundKey.

---
 rtl/inv_sub_bytes_seq.sv | 140 ++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes engine: BYTES_PER_CYCLE inverse S-box lookups per clock, valid/ready in and out.
// Define INV_SUB_BYTES_CNT_EN to add the blk_count completed-handshake counter port.
module inv_sub_bytes_seq #(
    parameter int unsigned regSize         = 32,
    parameter int unsigned vecSize         = 4,
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [vecSize-1:0][regSize-1:0]   state,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [vecSize-1:0][regSize-1:0]   new_state,
`ifdef INV_SUB_BYTES_CNT_EN
    output logic [31:0]                       blk_count,
`endif
    output logic                              busy
);

    localparam int unsigned SW     = regSize * vecSize;
    localparam int unsigned NB     = SW / 8;
    localparam int unsigned NSTEP  = NB / BYTES_PER_CYCLE;
    localparam int unsigned PTR_W  = $clog2(NB) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [1:0]       fsm_q, fsm_d;
    logic [SW-1:0]    work_q;
    logic [SW-1:0]    work_sub_c;
    logic [PTR_W-1:0] ptr_q;
    logic             last_c;
    logic [7:0]       sbox_in_c  [BYTES_PER_CYCLE];
    logic [7:0]       sbox_out_c [BYTES_PER_CYCLE];

    assign last_c = (ptr_q == PTR_W'(NB - BYTES_PER_CYCLE));

    // Next-state logic; in_ready is high exactly in IDLE, so in_valid alone qualifies acceptance.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (in_valid)  fsm_d = S_BUSY;
            S_BUSY:  if (last_c)    fsm_d = S_DONE;
            S_DONE:  if (out_ready) fsm_d = S_IDLE;
            default:                fsm_d = S_IDLE;
        endcase
    end

    // Select the current group of bytes for the replicated ROMs.
    always_comb begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            sbox_in_c[g] = '0;
            for (int s = 0; s < NSTEP; s++) begin
                if (ptr_q == PTR_W'(s * BYTES_PER_CYCLE))
                    sbox_in_c[g] = work_q[8*(s*BYTES_PER_CYCLE+g) +: 8];
            end
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_rom
        assign sbox_out_c[g] = INV_SBOX[sbox_in_c[g]];
    end

    // Working register with the current group substituted in place.
    always_comb begin
        work_sub_c = work_q;
        for (int s = 0; s < NSTEP; s++) begin
            if (ptr_q == PTR_W'(s * BYTES_PER_CYCLE)) begin
                for (int g = 0; g < BYTES_PER_CYCLE; g++)
                    work_sub_c[8*(s*BYTES_PER_CYCLE+g) +: 8] = sbox_out_c[g];
            end
        end
    end

    // State register, registered handshake flags and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            new_state <= '0;
            work_q    <= '0;
            ptr_q     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            in_ready  <= (fsm_d == S_IDLE);
            out_valid <= (fsm_d == S_DONE);
            busy      <= (fsm_d == S_BUSY);
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q <= state;
                        ptr_q  <= '0;
                    end
                end
                S_BUSY: begin
                    work_q <= work_sub_c;
                    ptr_q  <= ptr_q + PTR_W'(BYTES_PER_CYCLE);
                    if (last_c)
                        new_state <= work_sub_c;
                end
                default: ;
            endcase
        end
    end

`ifdef INV_SUB_BYTES_CNT_EN
    // Completed output handshakes, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst)
            blk_count <= '0;
        else if (out_valid && out_ready)
            blk_count <= blk_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq; reference inverse S-box derived from GF(2^8) arithmetic.
// Set BPC to exercise other BYTES_PER_CYCLE values; define INV_SUB_BYTES_CNT_EN to check blk_count.
module tb_inv_sub_bytes_seq;

    localparam int unsigned RS  = 32;
    localparam int unsigned VS  = 4;
    localparam int unsigned BPC = 4;
    localparam int unsigned W   = RS * VS;
    localparam int unsigned NB  = W / 8;
    localparam int unsigned LAT = NB / BPC + 1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic [VS-1:0][RS-1:0] state_i;
    logic out_valid;
    logic out_ready;
    logic [VS-1:0][RS-1:0] new_state;
    logic busy;
`ifdef INV_SUB_BYTES_CNT_EN
    logic [31:0] blk_count;
`endif

    int total = 0;
    int bad   = 0;

    inv_sub_bytes_seq #(.regSize(RS), .vecSize(VS), .BYTES_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .new_state (new_state),
`ifdef INV_SUB_BYTES_CNT_EN
        .blk_count (blk_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int z = 1; z < 256; z++)
            if (gmul(a, 8'(z)) == 8'h01) return 8'(z);
        return 8'h00;
    endfunction

    // Inverse affine transform followed by the multiplicative inverse.
    function automatic logic [7:0] inv_sbox_m(input logic [7:0] y);
        logic [7:0] b;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8] ^ d[i];
        return ginv(b);
    endfunction

    function automatic logic [W-1:0] ref_inv(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = inv_sbox_m(d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [W-1:0] fill(input logic [7:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE; hold = DONE cycles with out_ready low; pulse drives in_valid noise.
    task automatic run_block(input logic [W-1:0] d, input int hold, input bit pulse);
        logic [W-1:0] exp;
        logic [W-1:0] old;
        int cnt;
        exp = ref_inv(d);
        old = new_state;
        state_i  = d;
        in_valid = 1'b1;
        chk("accept_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        state_i   = rand_state();
        out_ready = 1'b1;
        cnt = 1;
        while (!out_valid && cnt < 64) begin
            chk("busy_high", W'(busy), W'(1));
            chk("no_partial", new_state, old);
            @(posedge clk); #1;
            cnt++;
        end
        out_ready = 1'b0;
        chk("latency", W'(cnt), W'(LAT));
        chk("result", new_state, exp);
        chk("done_in_ready", W'(in_ready), W'(0));
        chk("done_busy", W'(busy), W'(0));
        for (int i = 0; i < hold; i++) begin
            in_valid = pulse & (i % 2 == 0);
            @(posedge clk); #1;
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_stable", new_state, exp);
        end
        in_valid  = pulse;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("exit_valid", W'(out_valid), W'(0));
        chk("exit_in_ready", W'(in_ready), W'(1));
        chk("no_bypass", W'(busy), W'(0));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v1, e1, d;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_new_state", new_state, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        v1 = {32'h7575d2d2, 32'h7676c0c0, 32'h7b7bc5c5, 32'h63637c7c};
        e1 = {32'h3f3f7f7f, 32'h0f0f1f1f, 32'h03030707, 32'h00000101};
        run_block(v1, 0, 1'b0);
        chk("vec1_const", new_state, e1);

        run_block('0, 0, 1'b0);
        chk("zero_const", new_state, fill(8'h52));
        run_block(fill(8'h16), 0, 1'b0);
        chk("all16_const", new_state, fill(8'hff));

        run_block(rand_state(), 10, 1'b1);
        for (int i = 0; i < 6; i++)
            run_block(rand_state(), int'($urandom_range(0, 3)), 1'(i % 2));

        // Reset during the second BUSY cycle discards the partial result.
        state_i  = rand_state();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_new_state", new_state, '0);
        d = rand_state();
        run_block(d, 1, 1'b0);

`ifdef INV_SUB_BYTES_CNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("cnt_after_rst", W'(blk_count), W'(0));
        for (int i = 0; i < 3; i++)
            run_block(rand_state(), 0, 1'b0);
        chk("cnt_three", W'(blk_count), W'(3));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("cnt_cleared", W'(blk_count), W'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
